// File: rtl/int_pe_pkg.sv
// Shared types and width helper for the integer PE job sequencer.
package int_pe_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StResult
  } int_pe_seq_state_t;

  function automatic int unsigned pe_out_width(input int unsigned w_in_a, input int unsigned w_in_b);
    return w_in_a + w_in_b;
  endfunction

endpackage

// File: rtl/int_pe_len_counter.sv
// Loadable down-counter tracking the remaining operand pairs of a job.
module int_pe_len_counter #(
  parameter int unsigned W_LEN = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [W_LEN-1:0] load_value,
  input  logic             dec,
  output logic             last,
  output logic             zero
);

  logic [W_LEN-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = dec && (count_q == W_LEN'(1));
  assign zero = (count_q == '0);

endmodule

// File: rtl/int_pe_sequencer.sv
// Dot-product job sequencer driving one integer MAC PE.
// Define INT_PE_SEQ_SAT_EN to saturate the result to all ones on overflow.
module int_pe_sequencer
  import int_pe_pkg::*;
#(
  parameter int unsigned W_IN_A = 8,
  parameter int unsigned W_IN_B = 16,
  parameter int unsigned W_LEN  = 8,
  localparam int unsigned W_OUT_X = pe_out_width(W_IN_A, W_IN_B)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [W_LEN-1:0]   cmd_len,
  input  logic               cmd_bias_en,
  input  logic [W_OUT_X-1:0] cmd_bias,
  input  logic               abort,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [W_IN_A-1:0]  op_a,
  input  logic [W_IN_B-1:0]  op_b,
  output logic               pe_set_zero,
  output logic               pe_set,
  output logic [W_OUT_X-1:0] pe_set_value,
  output logic [W_IN_A-1:0]  pe_in_a,
  output logic [W_IN_B-1:0]  pe_in_b,
  input  logic [W_OUT_X-1:0] pe_out_x,
  input  logic               pe_adder_overflow,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [W_OUT_X-1:0] res_data,
  output logic               res_ovf,
  output logic               busy
);

  int_pe_seq_state_t state_q, state_d;
  logic sticky_q, sticky_d;
  logic cmd_fire, op_fire, res_fire;
  logic cnt_load, cnt_last, cnt_zero;
  logic [W_LEN-1:0] cnt_load_value;

  // Handshake readiness depends only on registered state and abort.
  assign cmd_ready = (state_q == StIdle) && !abort;
  assign op_ready  = (state_q == StAccum) && !abort && !cnt_zero;
  assign res_valid = (state_q == StResult) && !abort;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign op_fire  = op_valid && op_ready;
  assign res_fire = res_valid && res_ready;

  assign cnt_load       = cmd_fire || abort;
  assign cnt_load_value = abort ? '0 : cmd_len;

  int_pe_len_counter #(
    .W_LEN(W_LEN)
  ) u_len_counter (
    .clk        (clk),
    .rstn       (rstn),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (op_fire),
    .last       (cnt_last),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    sticky_d = sticky_q;
    if (abort) begin
      state_d  = StIdle;
      sticky_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_fire) begin
            sticky_d = 1'b0;
            state_d  = (cmd_len == '0) ? StResult : StAccum;
          end
        end
        StAccum: begin
          if (op_fire) begin
            sticky_d = sticky_q | pe_adder_overflow;
            if (cnt_last) begin
              state_d = StResult;
            end
          end
        end
        StResult: begin
          if (res_fire) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sticky_q <= sticky_d;
    end
  end

  assign pe_set       = cmd_fire && cmd_bias_en;
  assign pe_set_zero  = abort || (cmd_fire && !cmd_bias_en);
  assign pe_set_value = pe_set ? cmd_bias : '0;
  // Zero operands outside op fires so the PE accumulates nothing and holds.
  assign pe_in_a      = op_fire ? op_a : '0;
  assign pe_in_b      = op_fire ? op_b : '0;

  always_comb begin
    res_data = '0;
    res_ovf  = 1'b0;
    if (res_valid) begin
      res_ovf = sticky_q;
`ifdef INT_PE_SEQ_SAT_EN
      res_data = sticky_q ? {W_OUT_X{1'b1}} : pe_out_x;
`else
      res_data = pe_out_x;
`endif
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_int_pe_sequencer.sv
// Directed self-checking bench for int_pe_sequencer with a behavioural MAC PE model.
module tb_int_pe_sequencer;

  localparam int unsigned W_IN_A  = 8;
  localparam int unsigned W_IN_B  = 16;
  localparam int unsigned W_LEN   = 8;
  localparam int unsigned W_OUT_X = W_IN_A + W_IN_B;

  logic clk = 1'b0;
  logic rstn;
  logic cmd_valid, cmd_ready, cmd_bias_en, abort;
  logic [W_LEN-1:0] cmd_len;
  logic [W_OUT_X-1:0] cmd_bias;
  logic op_valid, op_ready;
  logic [W_IN_A-1:0] op_a;
  logic [W_IN_B-1:0] op_b;
  logic pe_set_zero, pe_set;
  logic [W_OUT_X-1:0] pe_set_value;
  logic [W_IN_A-1:0] pe_in_a;
  logic [W_IN_B-1:0] pe_in_b;
  logic [W_OUT_X-1:0] pe_out_x;
  logic pe_adder_overflow;
  logic res_valid, res_ready, res_ovf, busy;
  logic [W_OUT_X-1:0] res_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  int_pe_sequencer #(
    .W_IN_A(W_IN_A),
    .W_IN_B(W_IN_B),
    .W_LEN (W_LEN)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_len          (cmd_len),
    .cmd_bias_en      (cmd_bias_en),
    .cmd_bias         (cmd_bias),
    .abort            (abort),
    .op_valid         (op_valid),
    .op_ready         (op_ready),
    .op_a             (op_a),
    .op_b             (op_b),
    .pe_set_zero      (pe_set_zero),
    .pe_set           (pe_set),
    .pe_set_value     (pe_set_value),
    .pe_in_a          (pe_in_a),
    .pe_in_b          (pe_in_b),
    .pe_out_x         (pe_out_x),
    .pe_adder_overflow(pe_adder_overflow),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_ovf          (res_ovf),
    .busy             (busy)
  );

  // PE model: registered accumulator, combinational carry of the current add.
  logic [W_OUT_X:0] pe_sum;
  assign pe_sum = {1'b0, pe_out_x} + (W_OUT_X + 1)'(pe_in_a * pe_in_b);
  assign pe_adder_overflow = pe_sum[W_OUT_X];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pe_out_x <= '0;
    else if (pe_set_zero) pe_out_x <= '0;
    else if (pe_set) pe_out_x <= pe_set_value;
    else pe_out_x <= pe_sum[W_OUT_X-1:0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_len = '0; cmd_bias_en = 0; cmd_bias = '0; abort = 0;
    op_valid = 0; op_a = '0; op_b = '0; res_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0;
    #12;
    total++;
    if (cmd_ready !== 1'b1 || op_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_handshake: cmd_ready=%b op_ready=%b res_valid=%b busy=%b want 1 0 0 0",
               cmd_ready, op_ready, res_valid, busy);
    end
    total++;
    if (pe_set !== 1'b0 || pe_set_zero !== 1'b0 || pe_in_a !== '0 || pe_in_b !== '0 ||
        res_data !== '0 || res_ovf !== 1'b0 || pe_set_value !== '0) begin
      bad++;
      $display("FAIL reset_outputs: set=%b set_zero=%b in_a=%h in_b=%h res_data=%h ovf=%b want zeros",
               pe_set, pe_set_zero, pe_in_a, pe_in_b, res_data, res_ovf);
    end
    rstn = 1;
    tick();
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1; cmd_len = 8'd3; cmd_bias_en = 0;
    #1;
    total++;
    if (cmd_ready !== 1'b1 || pe_set_zero !== 1'b1 || pe_set !== 1'b0) begin
      bad++;
      $display("FAIL b2b_cmd: cmd_ready=%b set_zero=%b set=%b want 1 1 0", cmd_ready, pe_set_zero, pe_set);
    end
    tick();
    cmd_valid = 0; op_valid = 1; op_a = 8'd2; op_b = 16'd10;
    #1;
    total++;
    if (op_ready !== 1'b1 || pe_in_a !== 8'd2 || pe_in_b !== 16'd10 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_op0: op_ready=%b in_a=%0d in_b=%0d busy=%b want 1 2 10 1",
               op_ready, pe_in_a, pe_in_b, busy);
    end
    tick();
    op_a = 8'd3;
    tick();
    op_a = 8'd4;
    #1;
    total++;
    if (res_valid !== 1'b0 || pe_out_x !== 24'd50) begin
      bad++;
      $display("FAIL b2b_early: res_valid=%b pe_out=%0d want 0 50", res_valid, pe_out_x);
    end
    tick();
    op_valid = 0;
    #1;
    total++;
    if (res_valid !== 1'b1 || res_data !== 24'd90 || res_ovf !== 1'b0 || op_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_result: valid=%b data=%0d ovf=%b op_ready=%b want 1 90 0 0",
               res_valid, res_data, res_ovf, op_ready);
    end
    res_ready = 1;
    tick();
    res_ready = 0;
    #1;
    total++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: cmd_ready=%b res_valid=%b busy=%b want 1 0 0", cmd_ready, res_valid, busy);
    end
  endtask

  task automatic test_gapped_bias();
    cmd_valid = 1; cmd_len = 8'd1; cmd_bias_en = 1; cmd_bias = 24'd100;
    #1;
    total++;
    if (pe_set !== 1'b1 || pe_set_value !== 24'd100 || pe_set_zero !== 1'b0) begin
      bad++;
      $display("FAIL bias_cmd: set=%b value=%0d set_zero=%b want 1 100 0", pe_set, pe_set_value, pe_set_zero);
    end
    tick();
    cmd_valid = 0; cmd_bias_en = 0; cmd_bias = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (pe_in_a !== '0 || pe_in_b !== '0 || pe_out_x !== 24'd100 || pe_set !== 1'b0) begin
        bad++;
        $display("FAIL gap_hold[%0d]: in_a=%0d in_b=%0d pe_out=%0d set=%b want 0 0 100 0",
                 i, pe_in_a, pe_in_b, pe_out_x, pe_set);
      end
      tick();
    end
    op_valid = 1; op_a = 8'd1; op_b = 16'd1;
    tick();
    op_valid = 0;
    #1;
    total++;
    if (res_valid !== 1'b1 || res_data !== 24'd101) begin
      bad++;
      $display("FAIL bias_result: valid=%b data=%0d want 1 101", res_valid, res_data);
    end
    res_ready = 1;
    tick();
    res_ready = 0;
  endtask

  task automatic test_overflow();
    logic [W_OUT_X-1:0] exp_data;
`ifdef INT_PE_SEQ_SAT_EN
    exp_data = 24'hFFFFFF;
`else
    exp_data = 24'h000000;
`endif
    cmd_valid = 1; cmd_len = 8'd1; cmd_bias_en = 1; cmd_bias = 24'hFFFFFF;
    tick();
    cmd_valid = 0; cmd_bias_en = 0; cmd_bias = '0;
    op_valid = 1; op_a = 8'd1; op_b = 16'd1;
    tick();
    op_valid = 0;
    #1;
    total++;
    if (res_valid !== 1'b1 || res_ovf !== 1'b1 || res_data !== exp_data) begin
      bad++;
      $display("FAIL overflow: valid=%b ovf=%b data=%h want 1 1 %h", res_valid, res_ovf, res_data, exp_data);
    end
    res_ready = 1;
    tick();
    res_ready = 0;
  endtask

  task automatic test_zero_len();
    cmd_valid = 1; cmd_len = 8'd0; cmd_bias_en = 1; cmd_bias = 24'd5;
    tick();
    cmd_valid = 0; cmd_bias_en = 0; cmd_bias = '0; op_valid = 1; op_a = 8'd9; op_b = 16'd9;
    #1;
    total++;
    if (res_valid !== 1'b1 || res_data !== 24'd5 || op_ready !== 1'b0 || res_ovf !== 1'b0) begin
      bad++;
      $display("FAIL zero_len: valid=%b data=%0d op_ready=%b ovf=%b want 1 5 0 0",
               res_valid, res_data, op_ready, res_ovf);
    end
    res_ready = 1;
    tick();
    res_ready = 0; op_valid = 0;
  endtask

  task automatic test_backpressure();
    cmd_valid = 1; cmd_len = 8'd1; cmd_bias_en = 0;
    tick();
    cmd_valid = 0; op_valid = 1; op_a = 8'd6; op_b = 16'd5;
    tick();
    op_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (res_valid !== 1'b1 || res_data !== 24'd30 || cmd_ready !== 1'b0) begin
        bad++;
        $display("FAIL backpressure[%0d]: valid=%b data=%0d cmd_ready=%b want 1 30 0",
                 i, res_valid, res_data, cmd_ready);
      end
      tick();
    end
    res_ready = 1;
    tick();
    res_ready = 0;
    #1;
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL after_res_fire: cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_abort();
    cmd_valid = 1; cmd_len = 8'd5; cmd_bias_en = 0;
    tick();
    cmd_valid = 0; op_valid = 1; op_a = 8'd1; op_b = 16'd1;
    tick();
    tick();
    abort = 1;
    #1;
    total++;
    if (op_ready !== 1'b0 || pe_set_zero !== 1'b1 || pe_in_a !== '0 || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_cycle: op_ready=%b set_zero=%b in_a=%0d cmd_ready=%b want 0 1 0 0",
               op_ready, pe_set_zero, pe_in_a, cmd_ready);
    end
    tick();
    abort = 0; op_valid = 0;
    #1;
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1 || pe_out_x !== '0) begin
      bad++;
      $display("FAIL abort_idle: busy=%b res_valid=%b cmd_ready=%b pe_out=%0d want 0 0 1 0",
               busy, res_valid, cmd_ready, pe_out_x);
    end
    cmd_valid = 1; cmd_len = 8'd1;
    tick();
    cmd_valid = 0; op_valid = 1; op_a = 8'd7; op_b = 16'd3;
    tick();
    op_valid = 0;
    #1;
    total++;
    if (res_valid !== 1'b1 || res_data !== 24'd21 || res_ovf !== 1'b0) begin
      bad++;
      $display("FAIL after_abort: valid=%b data=%0d ovf=%b want 1 21 0", res_valid, res_data, res_ovf);
    end
    res_ready = 1;
    tick();
    res_ready = 0;
  endtask

  task automatic test_mid_reset();
    cmd_valid = 1; cmd_len = 8'd5; cmd_bias_en = 0;
    tick();
    cmd_valid = 0; op_valid = 1; op_a = 8'd3; op_b = 16'd4;
    tick();
    tick();
    op_valid = 0;
    rstn = 0;
    #1;
    total++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || op_ready !== 1'b0 || res_valid !== 1'b0 ||
        pe_set !== 1'b0 || pe_set_zero !== 1'b0 || res_data !== '0 || res_ovf !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: busy=%b cmd_ready=%b op_ready=%b res_valid=%b set=%b set_zero=%b data=%0d",
               busy, cmd_ready, op_ready, res_valid, pe_set, pe_set_zero, res_data);
    end
    tick();
    rstn = 1;
    tick();
    cmd_valid = 1; cmd_len = 8'd1;
    tick();
    cmd_valid = 0; op_valid = 1; op_a = 8'd2; op_b = 16'd2;
    tick();
    op_valid = 0;
    #1;
    total++;
    if (res_valid !== 1'b1 || res_data !== 24'd4) begin
      bad++;
      $display("FAIL post_reset_job: valid=%b data=%0d want 1 4", res_valid, res_data);
    end
    res_ready = 1;
    tick();
    res_ready = 0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped_bias();
    test_overflow();
    test_zero_len();
    test_backpressure();
    test_abort();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_pe_sequencer.md
# int_pe_sequencer

Job sequencer for one integer MAC processing element (PE: `in_a × in_b` accumulated into `partial_sum`, with `set_zero`/`set` preload and `adder_overflow` carry). It accepts a dot-product command (length, optional bias), streams operand pairs into the PE under valid/ready, and returns the accumulated result with a sticky overflow flag. It sits between the operand/command fabric and the PE, and is the only driver of the PE's control and operand inputs.

## Interface
- `W_IN_A`, 8, operand A width
- `W_IN_B`, 16, operand B width
- `W_LEN`, 8, command length width; maximum job length is 2^W_LEN−1
- `W_OUT_X`, derived (package function) `W_IN_A+W_IN_B`, result width; not overridable
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_len` in W_LEN: number of operand pairs.
- `cmd_bias_en` in 1, `cmd_bias` in W_OUT_X: preload value when enabled; zero otherwise.
- `abort` in 1: synchronous job cancel.
- `op_valid` in 1, `op_ready` out 1, `op_a` in W_IN_A, `op_b` in W_IN_B: operand stream.
- `pe_set_zero` out 1, `pe_set` out 1, `pe_set_value` out W_OUT_X: PE preload controls.
- `pe_in_a` out W_IN_A, `pe_in_b` out W_IN_B: PE operands.
- `pe_out_x` in W_OUT_X, `pe_adder_overflow` in 1: PE outputs.
- `res_valid` out 1, `res_ready` in 1, `res_data` out W_OUT_X, `res_ovf` out 1: result handshake.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, ACCUM, RESULT.
- IDLE: `cmd_ready`=1. On cmd fire, drive `pe_set`=1 with `pe_set_value`=`cmd_bias` if `cmd_bias_en`, else `pe_set_zero`=1. Load counter with `cmd_len` and clear sticky overflow. Go to ACCUM, or to RESULT if `cmd_len`=0.
- ACCUM: `op_ready`=1. On op fire:
  - drive `pe_in_a`/`pe_in_b` = `op_a`/`op_b`;
  - OR `pe_adder_overflow` into sticky;
  - decrement counter. When the counter reaches 0 on this fire, go to RESULT.
- `pe_in_a`/`pe_in_b` are zero in every cycle without an op fire, so the PE holds its value (adds 0). `pe_set`/`pe_set_zero` are asserted only on the cmd-fire cycle.
- RESULT: `res_valid`=1, `res_data`=`pe_out_x`, `res_ovf`=sticky. On res fire, go to IDLE.
- `abort` (any state, highest priority after reset): go to IDLE and assert `pe_set_zero` that cycle. No result is produced. `abort` masks `cmd_ready`, `op_ready` and `res_valid` in the same cycle.
- Arithmetic: unsigned; wraps modulo 2^W_OUT_X. Overflow is the PE carry, sampled only on op-fire cycles.

## Timing
- Reset: state IDLE, counter 0, sticky 0. All outputs are 0 except `cmd_ready`=1 (combinational from IDLE).
- `cmd_ready`, `op_ready` and `res_valid` are decoded from registered state only; there is no combinational path from `*_valid` to `*_ready`.
- Throughput: one operand pair per cycle in ACCUM.
- Latency: `res_valid` rises the cycle after the last op fire, or the cycle after cmd fire when `cmd_len`=0.
- Result is held stable under backpressure; the PE holds because its operands are zero.
- Minimum job gap: one IDLE cycle after res fire.
- Reset mid-job: returns immediately to the reset values; the partial result is discarded.

## Configuration
- `INT_PE_SEQ_SAT_EN` defined: if sticky overflow is set, `res_data` = all ones (saturate). `res_ovf` is still reported.
- `INT_PE_SEQ_SAT_EN` undefined: `res_data` = wrapped `pe_out_x`.

## Structure
- Package `int_pe_pkg` holds:
  - the state enum typedef `int_pe_seq_state_t`;
  - the width function `pe_out_width(W_IN_A, W_IN_B)`.
- One sub-module, `int_pe_len_counter`: a loadable down-counter with a `last` flag (count==1 and decrement) and a `zero` flag.

## Test plan
- len=3, no bias, (a,b)=(2,10),(3,10),(4,10) back-to-back → `res_data`=90, `res_ovf`=0, `res_valid` one cycle after the third fire.
- len=1, bias_en=1, bias=100, (1,1) with `op_valid` gapped by 3 idle cycles → 101; PE value unchanged during the gaps.
- W=8/16, len=1, bias=0xFFFFFF, (1,1) → `res_ovf`=1; `res_data`=0x000000, or 0xFFFFFF with `INT_PE_SEQ_SAT_EN`.
- len=0, bias=5 → `res_valid` the cycle after cmd fire, `res_data`=5, and `op_ready` never asserts.
- `res_ready` held low 4 cycles, then high → `res_data` stable for all 4 cycles; `cmd_ready`=1 the cycle after res fire.
- `abort` after 2 of 5 ops, then a new job len=1 with (7,3) → no result for the aborted job; new `res_data`=21. A repeat with `rstn` pulsed mid-ACCUM gives all outputs at reset values.
